cla_serial_add_ctrl: RTL

Sequencer that performs wide add/subtract by stepping one 8-bit carry-lookahead slice over NBYTES byte lanes, LSB byte first, chaining carry between cycles. The block sits between a requester (valid/ready) and a consumer (valid/ready). It lets one 8-bit lookahead datapath serve operands of 8*NBYTES bits. It holds one operation at a time and reports carry-out and signed overflow.

---
 rtl/cla_serial_add_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/cla_serial_add_ctrl.sv
// cla_serial_add_ctrl
// Wide add/subtract sequencer. One 8-bit carry-lookahead slice is stepped
// over NBYTES byte lanes, least significant lane first, with the carry held
// in a register between cycles. One operation is held at a time.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   requester presents operands
//   in_ready   block can accept (IDLE only)
//   a, b       W-bit operands, sampled on accept
//   sub        0: a+b, 1: a-b, sampled on accept
//   out_valid  result available (DONE only)
//   out_ready  consumer takes the result
//   sum        W-bit registered result
//   cout       carry out of the MSB (for subtract, 1 means no borrow)
//   ovf        signed two's-complement overflow
//   busy       an operation is in flight or waiting to be taken
module cla_serial_add_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout,
  output logic                  ovf,
  output logic                  busy
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [IW-1:0]   idx;
  logic            carry;
  logic [W-1:0]    opa;
  logic [W-1:0]    opb;

  logic [7:0]      x;
  logic [7:0]      y;
  logic [7:0]      g;
  logic [7:0]      p;
  logic [8:0]      c;
  logic [7:0]      slice_sum;
  logic            last;

  // Pick the current byte lane of both operands. A lane-compare loop keeps
  // the index arithmetic free of width games for any NBYTES.
  always_comb begin
    x = '0;
    y = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (idx == IW'(k)) begin
        x = opa[8*k +: 8];
        y = opb[8*k +: 8];
      end
    end
  end

  // 8-bit lookahead slice. The carry entering bit 0 is the carry left over
  // from the previous lane (or the subtract +1 on the first lane).
  always_comb begin
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = carry;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    slice_sum = p ^ c[7:0];
    last      = (idx == IW'(NBYTES - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs. in_ready is only high in IDLE, so an
  // in_valid seen in IDLE is an accept.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_nxt = ADD;
        end
      end
      ADD: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath registers. Subtract is folded in at accept time as A + ~B + 1,
  // so the ADD lanes never need to know which operation is running. The
  // operand registers are not reset: they are always loaded before use.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub;
            idx   <= '0;
            sum   <= '0;
          end
        end
        ADD: begin
          for (int k = 0; k < NBYTES; k++) begin
            if (idx == IW'(k)) begin
              sum[8*k +: 8] <= slice_sum;
            end
          end
          carry <= c[8];
          if (last) begin
            cout <= c[8];
            ovf  <= c[8] ^ c[7];
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
